// File: rtl/game_ctrl_if.sv
// Button/display bundle between the input conditioning and game_ctrl.
// master drives buttons and ticks; slave is the sequencer.
interface game_ctrl_if;
    logic       frame_tick;
    logic       pause;
    logic       jump;
    logic       duck;
    logic       adj;
    logic [2:0] num;
    logic       collide;
    logic [1:0] game_state;
    logic       running;
    logic [7:0] jump_h;
    logic       ducking;
    logic [3:0] lvl10;
    logic [3:0] lvl1;
    logic [3:0] score10;
    logic [3:0] score1;

    modport master (
        output frame_tick, pause, jump, duck, adj, num, collide,
        input  game_state, running, jump_h, ducking,
        input  lvl10, lvl1, score10, score1
    );

    modport slave (
        input  frame_tick, pause, jump, duck, adj, num, collide,
        output game_state, running, jump_h, ducking,
        output lvl10, lvl1, score10, score1
    );
endinterface

// File: rtl/game_ctrl.sv
// Runner game sequencer: game/jump FSMs, BCD level and score counters.
// Define GAME_CTRL_AUTOLEVEL_EN to raise the level every POINTS_PER_LEVEL points.
module game_ctrl #(
    parameter int FRAMES_PER_POINT = 30,
    parameter int JUMP_HEIGHT      = 60,
    parameter int JUMP_STEP        = 4,
    parameter int MAX_LEVEL        = 9,
    parameter int POINTS_PER_LEVEL = 10
) (
    input  logic       clk,
    input  logic       clr,
    game_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        J_GROUND = 2'd0,
        J_RISE   = 2'd1,
        J_FALL   = 2'd2
    } jump_t;

    localparam int FCW = (FRAMES_PER_POINT > 1) ? $clog2(FRAMES_PER_POINT) : 1;
    localparam logic [FCW-1:0] FC_LAST = FCW'(FRAMES_PER_POINT - 1);
    localparam logic [8:0] JH_MAX = 9'(JUMP_HEIGHT);
    localparam logic [8:0] JSTEP  = 9'(JUMP_STEP);
    localparam logic [7:0] JSTEP8 = 8'(JUMP_STEP);
    localparam logic [3:0] ML10   = 4'(MAX_LEVEL / 10);
    localparam logic [3:0] ML1    = 4'(MAX_LEVEL % 10);

    if (FRAMES_PER_POINT < 1 || JUMP_STEP < 1 || JUMP_STEP > JUMP_HEIGHT ||
        JUMP_HEIGHT > 255 || MAX_LEVEL < 1 || MAX_LEVEL > 99 ||
        POINTS_PER_LEVEL < 1) begin : g_bad_param
        $error("game_ctrl: parameter out of range");
    end

    state_t         r_state, w_state_n;
    jump_t          r_jst, w_jst_n;
    logic [7:0]     r_jh, w_jh_n;
    logic [3:0]     r_lvl10, w_lvl10_n;
    logic [3:0]     r_lvl1, w_lvl1_n;
    logic [3:0]     r_sc10, w_sc10_n;
    logic [3:0]     r_sc1, w_sc1_n;
    logic [FCW-1:0] r_fcnt, w_fcnt_n;
    logic           r_pause_q, r_jump_q;
    logic           r_duck, r_run;

    logic       w_pause_e, w_jump_e;
    logic       w_tick, w_point;
    logic [3:0] w_num_lvl;
    logic [8:0] w_rise;

`ifdef GAME_CTRL_AUTOLEVEL_EN
    localparam int PCW = (POINTS_PER_LEVEL > 1) ? $clog2(POINTS_PER_LEVEL) : 1;
    localparam logic [PCW-1:0] PC_LAST = PCW'(POINTS_PER_LEVEL - 1);
    logic [PCW-1:0] r_pcnt, w_pcnt_n;
`endif

    assign w_pause_e = bus.pause & ~r_pause_q;
    assign w_jump_e  = bus.jump & ~r_jump_q;
    assign w_rise    = {1'b0, r_jh} + JSTEP;

    // num is 3 bits, so the requested level never needs a tens digit
    always_comb begin
        w_num_lvl = {1'b0, bus.num};
        if (bus.num == 3'd0)
            w_num_lvl = 4'd1;
        else if ({29'd0, bus.num} > 32'(MAX_LEVEL))
            w_num_lvl = ML1;
    end

    always_comb begin
        w_state_n = r_state;
        w_jst_n   = r_jst;
        w_jh_n    = r_jh;
        w_lvl10_n = r_lvl10;
        w_lvl1_n  = r_lvl1;
        w_sc10_n  = r_sc10;
        w_sc1_n   = r_sc1;
        w_fcnt_n  = r_fcnt;
        w_tick    = 1'b0;
        w_point   = 1'b0;
`ifdef GAME_CTRL_AUTOLEVEL_EN
        w_pcnt_n  = r_pcnt;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (bus.adj) begin
                    w_lvl10_n = 4'd0;
                    w_lvl1_n  = w_num_lvl;
                end
                if (w_jump_e) begin
                    w_state_n = S_RUN;
                    w_sc10_n  = 4'd0;
                    w_sc1_n   = 4'd0;
                    w_fcnt_n  = '0;
`ifdef GAME_CTRL_AUTOLEVEL_EN
                    w_pcnt_n  = '0;
`endif
                end
            end
            S_RUN: begin
                if (bus.collide) begin
                    w_state_n = S_OVER;
                end else if (w_pause_e) begin
                    w_state_n = S_PAUSE;
                end else begin
                    w_tick = bus.frame_tick;
                    if (w_jump_e && r_jst == J_GROUND)
                        w_jst_n = J_RISE;
                end
            end
            S_PAUSE: begin
                if (bus.adj) begin
                    w_lvl10_n = 4'd0;
                    w_lvl1_n  = w_num_lvl;
                end
                if (w_pause_e)
                    w_state_n = S_RUN;
            end
            S_OVER: begin
                if (w_jump_e) begin
                    w_state_n = S_IDLE;
                    w_jst_n   = J_GROUND;
                    w_jh_n    = 8'd0;
                end
            end
        endcase

        // tick acts on the pre-edge jump phase; GROUND ignores it
        if (w_tick) begin
            if (r_fcnt == FC_LAST) begin
                w_fcnt_n = '0;
                w_point  = 1'b1;
            end else begin
                w_fcnt_n = r_fcnt + 1'b1;
            end
            unique case (r_jst)
                J_RISE: begin
                    if (w_rise >= JH_MAX) begin
                        w_jh_n  = JH_MAX[7:0];
                        w_jst_n = J_FALL;
                    end else begin
                        w_jh_n = w_rise[7:0];
                    end
                end
                J_FALL: begin
                    if ({1'b0, r_jh} <= JSTEP) begin
                        w_jh_n  = 8'd0;
                        w_jst_n = J_GROUND;
                    end else begin
                        w_jh_n = r_jh - JSTEP8;
                    end
                end
                default: ;
            endcase
        end

        if (w_point && !(r_sc10 == 4'd9 && r_sc1 == 4'd9)) begin
            if (r_sc1 == 4'd9) begin
                w_sc1_n  = 4'd0;
                w_sc10_n = r_sc10 + 4'd1;
            end else begin
                w_sc1_n = r_sc1 + 4'd1;
            end
`ifdef GAME_CTRL_AUTOLEVEL_EN
            if (r_pcnt == PC_LAST) begin
                w_pcnt_n = '0;
                if (!(r_lvl10 == ML10 && r_lvl1 == ML1)) begin
                    if (r_lvl1 == 4'd9) begin
                        w_lvl1_n  = 4'd0;
                        w_lvl10_n = r_lvl10 + 4'd1;
                    end else begin
                        w_lvl1_n = r_lvl1 + 4'd1;
                    end
                end
            end else begin
                w_pcnt_n = r_pcnt + 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= S_IDLE;
            r_jst     <= J_GROUND;
            r_jh      <= 8'd0;
            r_lvl10   <= 4'd0;
            r_lvl1    <= 4'd1;
            r_sc10    <= 4'd0;
            r_sc1     <= 4'd0;
            r_fcnt    <= '0;
            r_pause_q <= bus.pause;
            r_jump_q  <= bus.jump;
            r_duck    <= 1'b0;
            r_run     <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_jst     <= w_jst_n;
            r_jh      <= w_jh_n;
            r_lvl10   <= w_lvl10_n;
            r_lvl1    <= w_lvl1_n;
            r_sc10    <= w_sc10_n;
            r_sc1     <= w_sc1_n;
            r_fcnt    <= w_fcnt_n;
            r_pause_q <= bus.pause;
            r_jump_q  <= bus.jump;
            r_duck    <= bus.duck & (r_jst == J_GROUND) & (r_state == S_RUN);
            r_run     <= (w_state_n == S_RUN);
        end
    end

`ifdef GAME_CTRL_AUTOLEVEL_EN
    always_ff @(posedge clk) begin
        if (clr)
            r_pcnt <= '0;
        else
            r_pcnt <= w_pcnt_n;
    end
`endif

    assign bus.game_state = r_state;
    assign bus.running    = r_run;
    assign bus.jump_h     = r_jh;
    assign bus.ducking    = r_duck;
    assign bus.lvl10      = r_lvl10;
    assign bus.lvl1       = r_lvl1;
    assign bus.score10    = r_sc10;
    assign bus.score1     = r_sc1;
endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: directed scenarios then random play,
// expected outputs come from an integer-level game model.
module tb_game_ctrl;
    localparam int FPP  = 3;
    localparam int JH   = 8;
    localparam int JS   = 4;
    localparam int MAXL = 9;
    localparam int PPL  = 10;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    game_ctrl_if gi();

    game_ctrl #(
        .FRAMES_PER_POINT(FPP),
        .JUMP_HEIGHT(JH),
        .JUMP_STEP(JS),
        .MAX_LEVEL(MAXL),
        .POINTS_PER_LEVEL(PPL)
    ) u_dut (
        .clk(clk),
        .clr(clr),
        .bus(gi.slave)
    );

    typedef struct packed {
        logic [1:0] st;
        logic       run;
        logic [7:0] jh;
        logic       dk;
        logic [3:0] l10;
        logic [3:0] l1;
        logic [3:0] s10;
        logic [3:0] s1;
    } obs_t;

    obs_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // model state: game mode 0..3, plain integer level/score/height
    int m_st, m_lvl, m_sc, m_fc, m_jh, m_air, m_dk;
    logic m_pp, m_jp;

    function automatic int req_level(input int n);
        if (n == 0) return 1;
        return (n > MAXL) ? MAXL : n;
    endfunction

    task automatic model_step();
        obs_t e;
        bit pe, je;
        int air0;
        if (clr) begin
            m_st = 0; m_lvl = 1; m_sc = 0; m_fc = 0;
            m_jh = 0; m_air = 0; m_dk = 0;
        end else begin
            pe = gi.pause && !m_pp;
            je = gi.jump && !m_jp;
            m_dk = (gi.duck && m_air == 0 && m_st == 1) ? 1 : 0;
            air0 = m_air;
            case (m_st)
                0: begin
                    if (gi.adj) m_lvl = req_level(int'(gi.num));
                    if (je) begin m_st = 1; m_sc = 0; m_fc = 0; end
                end
                1: begin
                    if (gi.collide) m_st = 3;
                    else if (pe) m_st = 2;
                    else begin
                        if (gi.frame_tick) begin
                            m_fc = m_fc + 1;
                            if (m_fc == FPP) begin
                                m_fc = 0;
                                if (m_sc < 99) begin
                                    m_sc = m_sc + 1;
`ifdef GAME_CTRL_AUTOLEVEL_EN
                                    if (m_sc % PPL == 0 && m_lvl < MAXL)
                                        m_lvl = m_lvl + 1;
`endif
                                end
                            end
                            if (air0 == 1) begin
                                m_jh = m_jh + JS;
                                if (m_jh >= JH) begin m_jh = JH; m_air = 2; end
                            end else if (air0 == 2) begin
                                if (m_jh <= JS) begin m_jh = 0; m_air = 0; end
                                else m_jh = m_jh - JS;
                            end
                        end
                        if (je && air0 == 0) m_air = 1;
                    end
                end
                2: begin
                    if (gi.adj) m_lvl = req_level(int'(gi.num));
                    if (pe) m_st = 1;
                end
                default: begin
                    if (je) begin m_st = 0; m_air = 0; m_jh = 0; end
                end
            endcase
        end
        m_pp = gi.pause;
        m_jp = gi.jump;
        e.st  = 2'(m_st);
        e.run = (m_st == 1);
        e.jh  = 8'(m_jh);
        e.dk  = (m_dk != 0);
        e.l10 = 4'(m_lvl / 10);
        e.l1  = 4'(m_lvl % 10);
        e.s10 = 4'(m_sc / 10);
        e.s1  = 4'(m_sc % 10);
        q.push_back(e);
    endtask

    task automatic step(input logic ft);
        gi.frame_tick = ft;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic spot(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t a;
        a.st  = gi.game_state;
        a.run = gi.running;
        a.jh  = gi.jump_h;
        a.dk  = gi.ducking;
        a.l10 = gi.lvl10;
        a.l1  = gi.lvl1;
        a.s10 = gi.score10;
        a.s1  = gi.score1;
        return a;
    endfunction

    always begin
        obs_t e, a;
        @(posedge clk);
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = sample();
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL out @%0t: got st=%0d run=%0d jh=%0d dk=%0d lvl=%0d%0d sc=%0d%0d expected st=%0d run=%0d jh=%0d dk=%0d lvl=%0d%0d sc=%0d%0d",
                         $time, a.st, a.run, a.jh, a.dk, a.l10, a.l1, a.s10, a.s1,
                         e.st, e.run, e.jh, e.dk, e.l10, e.l1, e.s10, e.s1);
            end
        end
    end

    initial begin
        gi.frame_tick = 0; gi.pause = 0; gi.jump = 1; gi.duck = 0;
        gi.adj = 0; gi.num = 0; gi.collide = 0;
        m_pp = 0; m_jp = 0;

        // reset with jump held: no start afterwards
        clr = 1; step(0); step(0);
        clr = 0; step(0); step(0); step(0);
        spot("rst_state", int'(gi.game_state), 0);
        spot("rst_level", int'({gi.lvl10, gi.lvl1}), 8'h01);
        spot("rst_score", int'({gi.score10, gi.score1}), 8'h00);
        spot("rst_jump_h", int'(gi.jump_h), 0);

        // start, then 9 ticks and 30 ticks
        gi.jump = 0; step(0);
        gi.jump = 1; step(0);
        gi.jump = 0;
        for (int i = 0; i < 9; i++) begin step(1); step(0); end
        spot("run_state", int'(gi.game_state), 1);
        spot("score_9t", int'({gi.score10, gi.score1}), 8'h03);
        spot("jh_run", int'(gi.jump_h), 0);
        for (int i = 0; i < 21; i++) step(1);
        spot("score_30t", int'({gi.score10, gi.score1}), 8'h10);

        // jump arc with an ignored edge at the apex
        gi.jump = 1; step(0);
        gi.jump = 0; step(1);
        spot("jh_a", int'(gi.jump_h), 4);
        step(1);
        spot("jh_apex", int'(gi.jump_h), 8);
        gi.jump = 1; step(0);
        gi.jump = 0; step(1);
        spot("jh_fall", int'(gi.jump_h), 4);
        step(1);
        spot("jh_land", int'(gi.jump_h), 0);
        step(1);
        spot("jh_ground", int'(gi.jump_h), 0);

        // pause mid-rise freezes height and score
        gi.jump = 1; step(0);
        gi.jump = 0; step(1);
        gi.pause = 1; step(0);
        gi.pause = 0;
        for (int i = 0; i < 5; i++) step(1);
        spot("pause_state", int'(gi.game_state), 2);
        spot("pause_jh", int'(gi.jump_h), 4);
        gi.pause = 1; step(0);
        gi.pause = 0; step(1);
        spot("resume_jh", int'(gi.jump_h), 8);

        // collide beats pause; then back to idle
        gi.collide = 1; gi.pause = 1; step(0);
        gi.collide = 0; gi.pause = 0; step(0);
        spot("over_state", int'(gi.game_state), 3);
        gi.jump = 1; step(0);
        gi.jump = 0; step(0);
        spot("idle_state", int'(gi.game_state), 0);

        // level loading
        gi.adj = 1; gi.num = 0; step(0);
        spot("lvl_num0", int'({gi.lvl10, gi.lvl1}), 8'h01);
        gi.num = 7; step(0);
        spot("lvl_num7", int'({gi.lvl10, gi.lvl1}), 8'h07);
        gi.adj = 0; gi.jump = 1; step(0);
        gi.jump = 0; gi.adj = 1; gi.num = 3; step(0); step(0);
        spot("lvl_run_adj", int'({gi.lvl10, gi.lvl1}), 8'h07);
        gi.adj = 0;

        // random play
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(11) == 0) gi.jump = ~gi.jump;
            if ($urandom_range(39) == 0) gi.pause = ~gi.pause;
            if ($urandom_range(3) == 0) gi.duck = ~gi.duck;
            gi.collide = ($urandom_range(149) == 0);
            gi.adj = ($urandom_range(9) == 0);
            gi.num = 3'($urandom_range(7));
            clr = ($urandom_range(699) == 0);
            step($urandom_range(2) == 0);
        end
        clr = 0;
        gi.collide = 0;
        step(0);

        // clr mid-game
        clr = 1; step(0);
        clr = 0;
        spot("clr_state", int'(gi.game_state), 0);
        spot("clr_score", int'({gi.score10, gi.score1}), 8'h00);

        #10;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
